// File: rtl/muller_c_pkg.sv
// Shared limits and masked-compare helpers for the Muller C-element bank.
package muller_c_pkg;

   localparam int CHANNELS_MIN    = 1;
   localparam int CHANNELS_MAX    = 16;
   localparam int N_IN_MIN        = 2;
   localparam int N_IN_MAX        = 8;
   localparam int SYNC_STAGES_MAX = 3;

   // True when every bit selected by mask is 1 in vec (vacuously true for an empty mask).
   function automatic logic all_ones_masked(input logic [N_IN_MAX-1:0] vec,
                                            input logic [N_IN_MAX-1:0] mask);
      return ((vec & mask) == mask);
   endfunction

   // True when every bit selected by mask is 0 in vec (vacuously true for an empty mask).
   function automatic logic all_zeros_masked(input logic [N_IN_MAX-1:0] vec,
                                             input logic [N_IN_MAX-1:0] mask);
      return ((vec & mask) == '0);
   endfunction

   function automatic logic reset_val_ok(input int v);
      return (v == 0) || (v == 1);
   endfunction

   function automatic logic channels_ok(input int c);
      return (c >= CHANNELS_MIN) && (c <= CHANNELS_MAX);
   endfunction

   function automatic logic n_in_ok(input int n);
      return (n >= N_IN_MIN) && (n <= N_IN_MAX);
   endfunction

   function automatic logic sync_ok(input int s);
      return (s >= 0) && (s <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One generalised C-element channel: input synchroniser, state bit and
// transition counter. Rise and fall conditions use independent masks so the
// element can be made asymmetric at run time.
module muller_c_cell
   import muller_c_pkg::*;
#(
   parameter int N_IN        = 3,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int RESET_VAL   = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_IN-1:0]  i_in,
   input  logic [N_IN-1:0]  i_plus_mask,
   input  logic [N_IN-1:0]  i_minus_mask,
   input  logic             i_en,
   output logic             o_c_out,
   output logic [CNT_W-1:0] o_toggle_cnt
);

   logic [N_IN-1:0]     w_s_in;
   logic [N_IN_MAX-1:0] w_s_ext;
   logic [N_IN_MAX-1:0] w_plus_ext;
   logic [N_IN_MAX-1:0] w_minus_ext;
   logic                w_rise;
   logic                w_fall;
   logic                w_flip;

   logic                r_c_out;
   logic [CNT_W-1:0]    r_toggle_cnt;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_s_in = i_in;
      end else begin : g_sync
         logic [N_IN-1:0] r_sync [SYNC_STAGES];

         // Shift the raw inputs through the synchroniser chain.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  r_sync[i] <= '0;
               end
            end else begin
               r_sync[0] <= i_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_sync[i] <= r_sync[i-1];
               end
            end
         end

         assign w_s_in = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_s_ext     = N_IN_MAX'(w_s_in);
   assign w_plus_ext  = N_IN_MAX'(i_plus_mask);
   assign w_minus_ext = N_IN_MAX'(i_minus_mask);

   // An empty mask must disable its transition, so the vacuous truth of the
   // helpers is gated by a reduction-OR of the mask.
   assign w_rise = (|i_plus_mask)  & all_ones_masked(w_s_ext, w_plus_ext);
   assign w_fall = (|i_minus_mask) & all_zeros_masked(w_s_ext, w_minus_ext);

   // Only the condition leading away from the current state matters.
   assign w_flip = i_en & (r_c_out ? w_fall : w_rise);

   // State bit and its transition counter move together on each flip.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_c_out      <= 1'(RESET_VAL);
         r_toggle_cnt <= '0;
      end else if (w_flip) begin
         r_c_out      <= ~r_c_out;
         r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
      end
   end

   assign o_c_out      = r_c_out;
   assign o_toggle_cnt = r_toggle_cnt;

endmodule

// File: rtl/muller_c_bank.sv
// Bank of generalised Muller C-elements with a bank-wide 4-phase completion
// detector. The detector watches the registered element outputs and flips its
// phase once every enabled channel has reached the opposite level.
module muller_c_bank
   import muller_c_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int N_IN        = 3,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int PHASE_W     = 8,
   parameter int RESET_VAL   = 0
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [CHANNELS*N_IN-1:0]  in_i,
   input  logic [CHANNELS*N_IN-1:0]  plus_mask_i,
   input  logic [CHANNELS*N_IN-1:0]  minus_mask_i,
   input  logic [CHANNELS-1:0]       chan_en_i,
   output logic [CHANNELS-1:0]       c_out_o,
   output logic [CHANNELS*CNT_W-1:0] toggle_cnt_o,
   output logic                      phase_o,
   output logic                      phase_done_o,
   output logic [PHASE_W-1:0]        phase_cnt_o
);

   generate
      if (!channels_ok(CHANNELS)) begin : g_bad_channels
         $error("muller_c_bank: CHANNELS out of range");
      end
      if (!n_in_ok(N_IN)) begin : g_bad_n_in
         $error("muller_c_bank: N_IN out of range");
      end
      if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
         $error("muller_c_bank: SYNC_STAGES out of range");
      end
      if (!reset_val_ok(RESET_VAL)) begin : g_bad_reset_val
         $error("muller_c_bank: RESET_VAL must be 0 or 1");
      end
   endgenerate

   logic [CHANNELS-1:0] w_c_out;
   logic [CHANNELS-1:0] w_at_target;
   logic                w_fire;

   logic                r_phase;
   logic                r_phase_done;
   logic [PHASE_W-1:0]  r_phase_cnt;

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
         muller_c_cell #(
            .N_IN        (N_IN),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RESET_VAL   (RESET_VAL)
         ) u_cell (
            .i_clk        (wb_clk_i),
            .i_rst        (wb_rst_i),
            .i_in         (in_i[c*N_IN +: N_IN]),
            .i_plus_mask  (plus_mask_i[c*N_IN +: N_IN]),
            .i_minus_mask (minus_mask_i[c*N_IN +: N_IN]),
            .i_en         (chan_en_i[c]),
            .o_c_out      (w_c_out[c]),
            .o_toggle_cnt (toggle_cnt_o[c*CNT_W +: CNT_W])
         );
      end
   endgenerate

   // A channel has reached the target when its output differs from the
   // current phase; disabled channels are forced to count as reached, and an
   // all-disabled bank never fires.
   assign w_at_target = w_c_out ^ {CHANNELS{r_phase}};
   assign w_fire      = (|chan_en_i) & (&(w_at_target | ~chan_en_i));

   // Phase register, one-cycle completion pulse and wrapping phase counter.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_phase      <= 1'(RESET_VAL);
         r_phase_done <= 1'b0;
         r_phase_cnt  <= '0;
      end else begin
         r_phase_done <= w_fire;
         if (w_fire) begin
            r_phase     <= ~r_phase;
            r_phase_cnt <= r_phase_cnt + PHASE_W'(1);
         end
      end
   end

   assign c_out_o      = w_c_out;
   assign phase_o      = r_phase;
   assign phase_done_o = r_phase_done;
   assign phase_cnt_o  = r_phase_cnt;

endmodule

// File: tb/tb_muller_c_bank.sv
// Bench for muller_c_bank: directed scenarios plus random traffic, with every
// cycle compared against a behavioural model of the element bank.
module tb_muller_c_bank;

   localparam int CH = 2;
   localparam int NI = 3;
   localparam int CW = 8;
   localparam int PW = 8;

   logic              clk = 1'b0;
   logic              t_rst;
   logic [CH*NI-1:0]  t_in;
   logic [CH*NI-1:0]  t_plus;
   logic [CH*NI-1:0]  t_minus;
   logic [CH-1:0]     t_en;

   logic [CH-1:0]     c_out;
   logic [CH*CW-1:0]  tcnt;
   logic              phase;
   logic              phase_done;
   logic [PW-1:0]     phase_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   // behavioural model state
   logic [CH*NI-1:0]    m_q[$];
   logic [CH-1:0]       m_cout;
   logic [CH-1:0][CW-1:0] m_cnt;
   logic                m_phase;
   logic                m_done;
   logic [PW-1:0]       m_pcnt;

   muller_c_bank #(
      .CHANNELS    (CH),
      .N_IN        (NI),
      .SYNC_STAGES (2),
      .CNT_W       (CW),
      .PHASE_W     (PW),
      .RESET_VAL   (0)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (t_rst),
      .in_i         (t_in),
      .plus_mask_i  (t_plus),
      .minus_mask_i (t_minus),
      .chan_en_i    (t_en),
      .c_out_o      (c_out),
      .toggle_cnt_o (tcnt),
      .phase_o      (phase),
      .phase_done_o (phase_done),
      .phase_cnt_o  (phase_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_q.push_back('0);
      m_q.push_back('0);
      m_cout  = '0;
      m_cnt   = '0;
      m_phase = 1'b0;
      m_done  = 1'b0;
      m_pcnt  = '0;
   endtask

   // One clock edge: advance the model from the values present before the
   // edge, then compare every output just after it.
   task automatic step();
      logic [CH*NI-1:0] s;
      logic [NI-1:0]    sv, p, m;
      logic             fire;
      @(posedge clk);
      if (t_rst) begin
         model_reset();
      end else begin
         s    = m_q[0];
         fire = (t_en != '0);
         for (int c = 0; c < CH; c++) begin
            if (t_en[c] && (m_cout[c] == m_phase)) fire = 1'b0;
         end
         for (int c = 0; c < CH; c++) begin
            sv = s[c*NI +: NI];
            p  = t_plus[c*NI +: NI];
            m  = t_minus[c*NI +: NI];
            if (t_en[c]) begin
               if (!m_cout[c] && p != 0 && (sv & p) == p) begin
                  m_cout[c] = 1'b1;
                  m_cnt[c]  = m_cnt[c] + 8'd1;
               end else if (m_cout[c] && m != 0 && (sv & m) == 0) begin
                  m_cout[c] = 1'b0;
                  m_cnt[c]  = m_cnt[c] + 8'd1;
               end
            end
         end
         m_done = fire;
         if (fire) begin
            m_phase = ~m_phase;
            m_pcnt  = m_pcnt + 8'd1;
         end
         void'(m_q.pop_front());
         m_q.push_back(t_in);
      end
      #1;
      chk("m_cout",  32'(c_out),      32'(m_cout));
      chk("m_tcnt",  32'(tcnt),       32'(m_cnt));
      chk("m_phase", 32'(phase),      32'(m_phase));
      chk("m_done",  32'(phase_done), 32'(m_done));
      chk("m_pcnt",  32'(phase_cnt),  32'(m_pcnt));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      model_reset();
      t_rst   = 1'b1;
      t_in    = '0;
      t_plus  = '1;
      t_minus = '1;
      t_en    = 2'b11;

      // reset
      steps(2);
      t_rst = 1'b0;
      step();
      chk("rst_cout",  32'(c_out), 0);
      chk("rst_tcnt",  32'(tcnt), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_pcnt",  32'(phase_cnt), 0);
      chk("rst_done",  32'(phase_done), 0);

      // classic C-element on ch0
      t_in[2:0] = 3'b011;
      steps(4);
      chk("cls_partial", 32'(c_out[0]), 0);
      t_in[2:0] = 3'b111;
      steps(2);
      chk("cls_lat2", 32'(c_out[0]), 0);
      step();
      chk("cls_lat3", 32'(c_out[0]), 1);
      chk("cls_cnt1", 32'(tcnt[7:0]), 1);
      t_in[2:0] = 3'b001;
      steps(4);
      chk("cls_hold", 32'(c_out[0]), 1);
      t_in[2:0] = 3'b000;
      steps(3);
      chk("cls_fall", 32'(c_out[0]), 0);
      chk("cls_cnt2", 32'(tcnt[7:0]), 2);

      // asymmetric masks on ch1
      t_plus[5:3] = 3'b011;
      t_in[5:3]   = 3'b011;
      steps(3);
      chk("asy_rise", 32'(c_out[1]), 1);
      t_in[5:3] = 3'b010;
      steps(4);
      chk("asy_hold", 32'(c_out[1]), 1);
      t_in[5:3] = 3'b000;
      steps(3);
      chk("asy_fall", 32'(c_out[1]), 0);
      t_minus[5:3] = 3'b000;
      t_in[5:3]    = 3'b011;
      steps(3);
      t_in[5:3] = 3'b000;
      steps(4);
      chk("asy_nofall", 32'(c_out[1]), 1);
      t_plus  = '1;
      t_minus = '1;
      steps(3);
      chk("one_high_nopulse", 32'(phase_cnt), 0);

      // phase completion
      t_in = '1;
      steps(3);
      chk("ph_both_hi", 32'(c_out), 3);
      step();
      chk("ph1_done",  32'(phase_done), 1);
      chk("ph1_phase", 32'(phase), 1);
      chk("ph1_cnt",   32'(phase_cnt), 1);
      step();
      chk("ph1_pulse_len", 32'(phase_done), 0);
      t_in = '0;
      steps(4);
      chk("ph2_done",  32'(phase_done), 1);
      chk("ph2_phase", 32'(phase), 0);
      chk("ph2_cnt",   32'(phase_cnt), 2);

      // freeze ch1, complete on ch0 alone, then re-enable
      t_en      = 2'b01;
      t_in[5:3] = 3'b111;
      steps(4);
      chk("frz_hold", 32'(c_out[1]), 0);
      t_in[2:0] = 3'b111;
      steps(4);
      chk("frz_done",  32'(phase_done), 1);
      chk("frz_phase", 32'(phase), 1);
      t_en = 2'b11;
      step();
      chk("reen_rise", 32'(c_out[1]), 1);

      // mid-operation reset with c_out=11, phase=1
      t_rst = 1'b1;
      step();
      chk("mrst_cout",  32'(c_out), 0);
      chk("mrst_phase", 32'(phase), 0);
      chk("mrst_pcnt",  32'(phase_cnt), 0);
      chk("mrst_tcnt",  32'(tcnt), 0);
      t_rst = 1'b0;
      t_in  = '0;
      steps(3);

      // 256 toggles on ch0 wrap its counter
      for (int i = 0; i < 256; i++) begin
         t_in[2:0] = (i % 2 == 0) ? 3'b111 : 3'b000;
         step();
         if (i == 100) chk("wrap_mid", 32'(tcnt[7:0]), 32'(i - 1));
      end
      t_in = '0;
      steps(3);
      chk("wrap_cnt", 32'(tcnt[7:0]), 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         t_rst   = ($urandom_range(0, 59) == 0);
         t_in    = CH*NI'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            t_plus  = CH*NI'($urandom);
            t_minus = CH*NI'($urandom);
         end
         if ($urandom_range(0, 9) == 0) t_en = CH'($urandom);
         step();
      end
      t_rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/muller_c_bank.md
Name: muller_c_bank

Overview:
- Parametrised, clock-sampled bank of generalised Muller C-elements. Successor to the single fixed-width C-element project.
- Adds multiple channels and N-input elements with runtime asymmetric (plus/minus) masks.
- Adds input synchronisers, per-channel transition counters and a bank-wide 4-phase completion detector.
- Sits behind the user-project IO/logic-analyser bus as a self-timed-logic experiment block.

Parameters:
- CHANNELS, 4, number of independent C-elements (1..16)
- N_IN, 3, inputs per element (2..8)
- SYNC_STAGES, 2, synchroniser flops per input bit (0 = none, max 3)
- CNT_W, 8, width of each per-channel transition counter
- PHASE_W, 8, width of the completed-phase counter
- RESET_VAL, 0, reset value of all C-element outputs (0 or 1)

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  synchronous active-high reset
- in_i  in  CHANNELS*N_IN  element inputs; channel c uses bits [c*N_IN +: N_IN]; may be asynchronous
- plus_mask_i  in  CHANNELS*N_IN  1 = input participates in the rise condition
- minus_mask_i  in  CHANNELS*N_IN  1 = input participates in the fall condition
- chan_en_i  in  CHANNELS  1 = channel evaluates; 0 = channel frozen
- c_out_o  out  CHANNELS  registered C-element outputs
- toggle_cnt_o  out  CHANNELS*CNT_W  per-channel transition counts
- phase_o  out  1  current completed phase value
- phase_done_o  out  1  one-cycle pulse on phase completion
- phase_cnt_o  out  PHASE_W  number of completed phases, wraps

Behaviour:
- Reset is synchronous, active-high, on wb_clk_i. While wb_rst_i=1 at an edge:
  - sync flops <= 0
  - c_out_o <= {CHANNELS{RESET_VAL}}
  - toggle_cnt_o <= 0, phase_cnt_o <= 0, phase_done_o <= 0
  - phase_o <= RESET_VAL
- Reset asserted mid-operation overrides every update in that cycle.
- Synchroniser: in_i passes through SYNC_STAGES flops, giving s_in. With SYNC_STAGES=0, s_in = in_i.
- Masks and chan_en_i are sampled directly (quasi-static config, not synchronised).
- Per channel c, using s_in, plus_mask_i and minus_mask_i:
  - rise_c = (plus mask has at least one 1) AND (every s_in bit with plus bit 1 is 1)
  - fall_c = (minus mask has at least one 1) AND (every s_in bit with minus bit 1 is 0)
  - An all-zero mask disables that transition: the output can never take it.
- Next state when chan_en_i[c]=1:
  - c_out=0 and rise_c: c_out <= 1
  - c_out=1 and fall_c: c_out <= 0
  - otherwise hold. Only the condition matching the current state is examined, so simultaneous rise/fall truth is not a conflict.
- chan_en_i[c]=0: c_out and counter hold. Re-enabling resumes evaluation on the next edge with no glitch.
- Latency: a stable input change reaches c_out_o SYNC_STAGES+1 edges later.
- Counter: toggle_cnt[c] increments by 1 in the same edge c_out[c] changes, and wraps modulo 2^CNT_W.
- Phase detector, evaluated on registered c_out:
  - Fires when chan_en_i != 0 and every enabled channel has c_out == ~phase_o.
  - Next edge: phase_o toggles, phase_done_o=1 for exactly one cycle, phase_cnt_o increments (wraps).
  - Disabled channels are ignored.
  - With all channels disabled the detector never fires.
- Fully symmetric masks give classic C-element behaviour.

Decomposition:
- Package muller_c_pkg: N_IN and CHANNELS limits, function all_ones_masked(vec, mask), function all_zeros_masked(vec, mask), RESET_VAL localparam checks.
- Sub-module muller_c_cell: one channel (synchroniser, state bit, counter), instantiated CHANNELS times by generate.
- Top-level muller_c_bank holds the phase detector.

Test Plan (CHANNELS=2, N_IN=3, SYNC_STAGES=2, RESET_VAL=0, all masks 1, chan_en=2'b11 unless stated):
- Reset: hold wb_rst_i 2 cycles, then release -> c_out=00, counts 0, phase_o=0, phase_cnt=0, no phase_done pulse.
- Classic C-element: ch0 in=3'b011 -> c_out[0] stays 0; then in=3'b111 -> c_out[0]=1 exactly 3 edges later, toggle_cnt[0]=1; then in=3'b001 -> holds 1; then in=3'b000 -> 0, toggle_cnt[0]=2.
- Asymmetric: ch1 plus_mask=3'b011, minus_mask=3'b111, in=3'b011 -> c_out[1]=1; in=3'b010 -> holds; in=3'b000 -> 0. Minus_mask=000 -> never falls after rising.
- Phase completion: drive both channels to 1 -> single phase_done pulse, phase_o=1, phase_cnt=1; drive both to 0 -> second pulse, phase_o=0, phase_cnt=2. Only one channel high -> no pulse.
- Enable/freeze: chan_en=2'b01, raise ch1 inputs -> c_out[1] held 0, phase completes on ch0 alone; re-enable -> ch1 rises next edge.
- Wrap and mid-reset: 256 toggles on ch0 -> toggle_cnt[0]=0. Assert wb_rst_i with c_out=11 and phase_o=1 -> all outputs return to reset values on that edge.
